countdown_timer: RTL and testbench

Memory-mapped countdown/alarm timer, the CPU-writable counterpart of the free-running millisecond time source. Software loads a tick count and enables the block. An internal prescaler generates ticks, the count decrements, and on expiry the block sets a sticky flag and raises an optional interrupt. It sits on the IO bus next to the other memory-mapped peripherals and supports one-shot and periodic modes.

---
 rtl/countdown_timer_pkg.sv | 28 ++
 rtl/countdown_timer_if.sv | 28 ++
 rtl/countdown_timer_prescaler.sv | 39 +++
 rtl/countdown_timer.sv | 157 +++++++++++++++
 tb/tb_countdown_timer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// ----------------------------------------------------------------------------
// countdown_timer_pkg
// Shared definitions for the memory-mapped countdown timer: register select
// codes (byte offset bits [3:2]), CTRL/STATUS bit positions, FSM state type
// and the default prescaler ratio (1 ms ticks at 100 MHz).
// ----------------------------------------------------------------------------
package countdown_timer_pkg;

    localparam int unsigned DEFAULT_CYCLES_PER_TICK = 100_000;

    // Register select = byte offset [3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;   // 0x0
    localparam logic [1:0] REG_LOAD   = 2'd1;   // 0x4
    localparam logic [1:0] REG_COUNT  = 2'd2;   // 0x8
    localparam logic [1:0] REG_STATUS = 2'd3;   // 0xC

    localparam int unsigned CTRL_EN_BIT        = 0;
    localparam int unsigned CTRL_PERIODIC_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 2;
    localparam int unsigned STATUS_EXPIRED_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// ----------------------------------------------------------------------------
// countdown_timer_if
// IO-bus register port of the countdown timer.
//   addr   : byte offset, [3:2] select the register
//   wen    : one-cycle write strobe, wdata: write data
//   ren    : read strobe; rdata/rvalid return one cycle later
//   irq    : level interrupt from the peripheral
// master = CPU/bus side, slave = peripheral side.
// ----------------------------------------------------------------------------
interface countdown_timer_if;
    logic [3:0]  addr;
    logic        wen;
    logic [31:0] wdata;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    modport master (
        output addr, wen, wdata, ren,
        input  rdata, rvalid, irq
    );

    modport slave (
        input  addr, wen, wdata, ren,
        output rdata, rvalid, irq
    );
endinterface

// File: rtl/countdown_timer_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick pulse every CYCLES_PER_TICK cycles
// while i_run is high. The counter holds when i_run is low.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_run      : count enable
//   i_clear    : synchronous restart of the count at 0 (wins over i_run)
//   o_tick     : high for the cycle in which the count is CYCLES_PER_TICK-1
// ----------------------------------------------------------------------------
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_TICK = DEFAULT_CYCLES_PER_TICK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned PW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_TICK - 1);

    logic [PW-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
// CPU-writable countdown/alarm timer on the IO bus. Software writes LOAD,
// then CTRL.en=1; COUNT decrements once per prescaler tick and on expiry the
// sticky STATUS.expired flag is set and irq raised (if CTRL.irq_en).
// One-shot or periodic (auto-reload from LOAD) operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : register port (slave modport of countdown_timer_if)
// Registers: 0x0 CTRL{irq_en,periodic,en}, 0x4 LOAD, 0x8 COUNT (RO),
//            0xC STATUS{expired} (write 1 to clear)
// ----------------------------------------------------------------------------
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_TICK = DEFAULT_CYCLES_PER_TICK,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    countdown_timer_if.slave bus
);

    timer_state_t     r_state;
    logic             r_en;
    logic             r_periodic;
    logic             r_irq_en;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_count;
    logic             r_expired;
    logic             r_irq;
    logic [31:0]      r_rdata;
    logic             r_rvalid;

    logic [1:0]       w_sel;
    logic             w_ctrl_wr;
    logic             w_arm;
    logic             w_stop;
    logic             w_load_wr;
    logic             w_w1c;
    logic             w_tick;
    logic             w_expire;
    logic             w_set;
    logic             w_expired_next;
    logic             w_irq_en_next;
    logic [31:0]      w_rd_mux;
    logic             w_unused_addr;

    assign w_sel         = bus.addr[3:2];
    assign w_unused_addr = ^bus.addr[1:0];

    assign w_ctrl_wr = bus.wen && (w_sel == REG_CTRL);
    assign w_arm     = w_ctrl_wr &&  bus.wdata[CTRL_EN_BIT];
    assign w_stop    = w_ctrl_wr && !bus.wdata[CTRL_EN_BIT];
    assign w_load_wr = bus.wen && (w_sel == REG_LOAD);
    assign w_w1c     = bus.wen && (w_sel == REG_STATUS) && bus.wdata[STATUS_EXPIRED_BIT];

    // Entry into RUN (and restart while running) always starts a full tick.
    tick_prescaler #(
        .CYCLES_PER_TICK (CYCLES_PER_TICK)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_run   (r_state == ST_RUN),
        .i_clear (w_arm),
        .o_tick  (w_tick)
    );

    // A CTRL write takes priority over a coincident tick, so it also
    // suppresses the expiry that tick would have caused.
    assign w_expire = w_tick && !w_ctrl_wr && (r_count == CNT_W'(1));
    assign w_set    = w_expire || (w_arm && (r_load == '0));

    // Set beats a simultaneous write-1-to-clear.
    assign w_expired_next = w_set || (r_expired && !w_w1c);
    assign w_irq_en_next  = w_ctrl_wr ? bus.wdata[CTRL_IRQ_EN_BIT] : r_irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
            r_load     <= '0;
            r_count    <= '0;
            r_expired  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_expired <= w_expired_next;
            r_irq     <= w_expired_next && w_irq_en_next;

            if (w_ctrl_wr) begin
                r_en       <= bus.wdata[CTRL_EN_BIT];
                r_periodic <= bus.wdata[CTRL_PERIODIC_BIT];
                r_irq_en   <= bus.wdata[CTRL_IRQ_EN_BIT];
            end

            if (w_load_wr) begin
                r_load <= bus.wdata[CNT_W-1:0];
            end

            if (w_arm) begin
                r_count <= r_load;
                r_state <= (r_load == '0) ? ST_DONE : ST_RUN;
            end else if (w_stop) begin
                r_state <= ST_IDLE;
            end else if ((r_state == ST_RUN) && w_tick) begin
                if (r_count == CNT_W'(1)) begin
                    if (r_periodic) begin
                        r_count <= r_load;
                        if (r_load == '0) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_count <= '0;
                        r_state <= ST_DONE;
                    end
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_CTRL: begin
                w_rd_mux[CTRL_EN_BIT]       = r_en;
                w_rd_mux[CTRL_PERIODIC_BIT] = r_periodic;
                w_rd_mux[CTRL_IRQ_EN_BIT]   = r_irq_en;
            end
            REG_LOAD:   w_rd_mux[CNT_W-1:0] = r_load;
            REG_COUNT:  w_rd_mux[CNT_W-1:0] = r_count;
            REG_STATUS: w_rd_mux[STATUS_EXPIRED_BIT] = r_expired;
            default:    w_rd_mux = '0;
        endcase
    end

    // Read data samples pre-edge register values, so a read racing a write
    // to the same register returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= bus.ren;
            if (bus.ren) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.irq    = r_irq;

endmodule

// File: tb/tb_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer
// Scoreboard bench for countdown_timer with CYCLES_PER_TICK=4. Read requests
// push their expected data; a monitor pops and compares on each rvalid and
// also checks that rvalid follows ren by exactly one cycle. irq and reset
// values are checked directly.
// ----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int unsigned CPT = 4;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_LOAD   = 4'h4;
    localparam logic [3:0] A_COUNT  = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hC;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    countdown_timer_if bus ();

    countdown_timer #(
        .CYCLES_PER_TICK (CPT),
        .CNT_W           (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    logic        mon_ren_q;
    logic [31:0] mon_exp;
    string       mon_name;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: ren seen at an edge must give rvalid right after that edge.
    always @(posedge clk) begin
        mon_ren_q = bus.ren && rst_n;
        #1;
        if (mon_ren_q || bus.rvalid) begin
            check("rvalid_timing", 32'(bus.rvalid), 32'(mon_ren_q));
        end
        if (bus.rvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_rvalid: got rdata 0x%08h expected no read", bus.rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, bus.rdata, mon_exp);
            end
        end
    end

    // All tasks start and end at a falling edge; each access uses one edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wen   = 1'b1;
        @(negedge clk);
        bus.wen   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        bus.addr = a;
        bus.ren  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        bus.ren  = 1'b0;
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
        bus.addr  = a;
        bus.wdata = d;
        bus.wen   = 1'b1;
        bus.ren   = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        #2;
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_rvalid", 32'(bus.rvalid), 32'h0);
        check("reset_irq", 32'(bus.irq), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(A_COUNT, 32'h0, "reset_count");
        rd(A_STATUS, 32'h0, "reset_status");
        rd(A_CTRL, 32'h0, "reset_ctrl");

        // One-shot, LOAD=3: enable write at edge 0, expiry at edge 12.
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'h5);
        rd(A_COUNT, 32'd3, "oneshot_count3");
        idle(3);
        rd(A_COUNT, 32'd2, "oneshot_count2");
        idle(3);
        rd(A_COUNT, 32'd1, "oneshot_count1");
        idle(2);
        check("oneshot_irq_before", 32'(bus.irq), 32'h0);
        idle(1);
        check("oneshot_irq_at_expiry", 32'(bus.irq), 32'h1);
        rd(A_COUNT, 32'd0, "oneshot_count0");
        rd(A_STATUS, 32'h1, "oneshot_expired");
        wr(A_STATUS, 32'h1);
        check("oneshot_irq_cleared", 32'(bus.irq), 32'h0);
        rd(A_STATUS, 32'h0, "oneshot_status_cleared");
        idle(4);
        rd(A_COUNT, 32'd0, "oneshot_count_hold");

        // Periodic, LOAD=2: expiries at edges 8, 16.
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'h7);
        rd(A_COUNT, 32'd2, "per_count_a2");
        idle(3);
        rd(A_COUNT, 32'd1, "per_count_a1");
        idle(3);
        rd(A_COUNT, 32'd2, "per_count_b2");
        idle(3);
        rd(A_COUNT, 32'd1, "per_count_b1");
        rd(A_STATUS, 32'h1, "per_expired_first");
        wr(A_STATUS, 32'h1);
        check("per_irq_cleared", 32'(bus.irq), 32'h0);
        rd(A_STATUS, 32'h0, "per_status_cleared");
        check("per_irq_second", 32'(bus.irq), 32'h1);
        rd(A_STATUS, 32'h1, "per_expired_second");
        wr(A_CTRL, 32'h0);
        check("per_irq_en_off", 32'(bus.irq), 32'h0);
        wr(A_STATUS, 32'h1);
        idle(10);
        rd(A_COUNT, 32'd2, "per_count_frozen");
        rd(A_STATUS, 32'h0, "per_no_expiry_stopped");
        rd(A_CTRL, 32'h0, "per_ctrl_readback");

        // LOAD=0 enable: expired the cycle after the write, no retrigger.
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'h3);
        rd(A_STATUS, 32'h1, "zero_expired_next_cycle");
        check("zero_irq_disabled", 32'(bus.irq), 32'h0);
        rd(A_COUNT, 32'd0, "zero_count");
        wr(A_STATUS, 32'h1);
        idle(10);
        rd(A_STATUS, 32'h0, "zero_no_retrigger");
        rd(A_COUNT, 32'd0, "zero_count_hold");

        // W1C on the expiry edge (edge 4 for LOAD=1): set wins.
        wr(A_LOAD, 32'd1);
        wr(A_CTRL, 32'h1);
        idle(3);
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, 32'h1, "race_set_wins");
        rd(A_COUNT, 32'd0, "race_count");
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, 32'h0, "race_cleared");

        // Restart and LOAD update while running.
        wr(A_LOAD, 32'd7);
        wr(A_CTRL, 32'h1);
        idle(8);
        wr(A_LOAD, 32'd9);
        rd(A_COUNT, 32'd5, "restart_count5");
        idle(2);
        rd(A_COUNT, 32'd4, "restart_load_no_effect");
        wr(A_CTRL, 32'h1);
        rd(A_COUNT, 32'd9, "restart_reloaded");
        idle(2);
        rd(4'hB, 32'd9, "restart_presc_full_tick");
        rd(A_COUNT, 32'd8, "restart_first_decrement");
        wr(A_COUNT, 32'h55);
        rd(A_COUNT, 32'd8, "count_write_ignored");
        rdwr(A_LOAD, 32'h1234, 32'd9, "rw_same_cycle_old");
        rd(A_LOAD, 32'h1234, "rw_new_value");
        wr(A_CTRL, 32'hFFFF_FFF6);
        rd(A_CTRL, 32'h6, "ctrl_upper_bits_zero");
        idle(8);
        rd(A_COUNT, 32'd7, "stop_count_hold");

        // Asynchronous reset mid-run with irq asserted.
        wr(A_LOAD, 32'd1);
        wr(A_CTRL, 32'h7);
        idle(4);
        check("midrun_irq_high", 32'(bus.irq), 32'h1);
        rd(A_CTRL, 32'h7, "midrun_ctrl");
        rst_n = 1'b0;
        #1;
        check("midrun_reset_rdata", bus.rdata, 32'h0);
        check("midrun_reset_irq", 32'(bus.irq), 32'h0);
        check("midrun_reset_rvalid", 32'(bus.rvalid), 32'h0);
        idle(2);
        rst_n = 1'b1;
        rd(A_COUNT, 32'h0, "midrun_count");
        rd(A_STATUS, 32'h0, "midrun_status");
        rd(A_CTRL, 32'h0, "midrun_ctrl_cleared");
        rd(A_LOAD, 32'h0, "midrun_load");
        idle(8);
        rd(A_STATUS, 32'h0, "midrun_idle_status");
        check("midrun_idle_irq", 32'(bus.irq), 32'h0);

        idle(2);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
